// File: rtl/alu_seq_control.sv
// alu_seq_control: registered EX-stage ALU-op decode plus MULT/DIV sequencer.
// Optional undef_trap output enabled by ALU_SEQ_UNDEF_TRAP_EN.
package alu_seq_pkg;
    typedef enum logic [3:0] {
        ALU_NOP     = 4'd0,
        ALU_ADD     = 4'd1,
        ALU_SUB     = 4'd2,
        ALU_SLL     = 4'd3,
        ALU_SRA     = 4'd4,
        ALU_RS_PASS = 4'd5,
        ALU_AND     = 4'd6,
        ALU_OR      = 4'd7,
        ALU_SLLI    = 4'd8,
        ALU_SLT     = 4'd9,
        ALU_UNDEF   = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_e;
endpackage

module alu_seq_control
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DIV_CYCLES  = WIDTH,
    parameter int MULT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       valid_in,
    input  logic       flush,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op_q,
    output logic       md_start,
    output logic       md_is_div,
    output logic       md_signed,
    output logic       md_step,
    output logic       hilo_we,
    output logic       busy,
    output logic       stall
`ifdef ALU_SEQ_UNDEF_TRAP_EN
    ,
    output logic       undef_trap
`endif
);

    localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;

    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRA     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;

    md_state_e     state;
    md_state_e     state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          is_div_n;
    logic          signed_n;
    alu_op_e       sp_dec;
    alu_op_e       dec;
    logic [3:0]    alu_op_n;
    logic          is_special;
    logic          md_op;
    logic          hilo_rd;

    assign is_special = (opcode == OP_SPECIAL);
    assign md_op   = valid_in & is_special & (funct[5:2] == 4'b0110);
    assign hilo_rd = valid_in & is_special &
                     ((funct == FN_MFHI) | (funct == FN_MFLO));
    assign busy    = (state != S_IDLE);
    assign stall   = busy & (md_op | hilo_rd) & ~flush;

    always_comb begin
        sp_dec = ALU_UNDEF;
        case (funct)
            FN_ADD, FN_ADDU:   sp_dec = ALU_ADD;
            FN_SUBU:           sp_dec = ALU_SUB;
            FN_SLL:            sp_dec = ALU_SLL;
            FN_SRA:            sp_dec = ALU_SRA;
            FN_MFHI, FN_MFLO:  sp_dec = ALU_RS_PASS;
            FN_SYSCALL, FN_JR,
            FN_MULT, FN_MULTU,
            FN_DIV, FN_DIVU:   sp_dec = ALU_NOP;
            default:           sp_dec = ALU_UNDEF;
        endcase
    end

    always_comb begin
        dec = ALU_UNDEF;
        unique case (1'b1)
            is_special:              dec = sp_dec;
            (opcode == OP_SW),
            (opcode == OP_SB),
            (opcode == OP_LW),
            (opcode == OP_LB),
            (opcode == OP_ADDIU):    dec = ALU_ADD;
            (opcode == OP_ANDI):     dec = ALU_AND;
            (opcode == OP_ORI):      dec = ALU_OR;
            (opcode == OP_LUI):      dec = ALU_SLLI;
            (opcode == OP_SLTI),
            (opcode == OP_SLTIU):    dec = ALU_SLT;
            default:                 dec = ALU_UNDEF;
        endcase
    end

    assign alu_op_n = (flush | stall | ~valid_in) ? ALU_NOP : dec;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        is_div_n = md_is_div;
        signed_n = md_signed;
        md_start = 1'b0;
        md_step  = 1'b0;
        hilo_we  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (md_op && !flush) begin
                    state_n  = S_BUSY;
                    // keep the start pulse quiet while reset is held
                    md_start = reset_n;
                    is_div_n = funct[1];
                    signed_n = ~funct[0];
                    cnt_n    = funct[1] ? DIV_LOAD : MULT_LOAD;
                end
            end
            S_BUSY: begin
                md_step = 1'b1;
                if (flush) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_DONE: begin
                hilo_we = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            md_is_div <= 1'b0;
            md_signed <= 1'b0;
            alu_op_q  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            md_is_div <= is_div_n;
            md_signed <= signed_n;
            alu_op_q  <= alu_op_n;
        end
    end

`ifdef ALU_SEQ_UNDEF_TRAP_EN
    logic trap_n;

    assign trap_n = valid_in & ~flush & ~stall & (dec == ALU_UNDEF);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            undef_trap <= 1'b0;
        end else begin
            undef_trap <= trap_n;
        end
    end

    always @(posedge clock) begin
        if (reset_n && trap_n && ($time != 0)) begin
            $display("%0t alu_seq_control undefined op opcode=%b funct=%b",
                     $time, opcode, funct);
        end
    end
`endif

endmodule

// File: doc/alu_seq_control.md
Name: alu_seq_control

Overview:
Parametrised successor to the decode-stage ALU control. Decodes opcode/funct into a registered EX-stage alu_op. Adds a sequencer for multi-cycle MULT/MULTU/DIV/DIVU operations that drives the iterative mul/div datapath and HI/LO write-back. Generates decode-stage stall for HI/LO hazards and structural conflicts.

Parameters:
WIDTH, 32, operand width; sets divide iteration count.
DIV_CYCLES, WIDTH, BUSY cycles for DIV/DIVU; minimum 1.
MULT_CYCLES, 4, BUSY cycles for MULT/MULTU; minimum 1.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  instruction in decode is valid
flush  in  1  squash decode instruction and abort in-flight mul/div
opcode  in  6  instruction opcode
funct  in  6  instruction funct field
alu_op_q  out  4  registered ALU operation for EX stage
md_start  out  1  one-cycle pulse: latch operands, begin mul/div
md_is_div  out  1  latched: 1 = divide, 0 = multiply
md_signed  out  1  latched: 1 = MULT/DIV, 0 = MULTU/DIVU
md_step  out  1  advance iterative datapath one step
hilo_we  out  1  one-cycle pulse: write HI/LO from datapath
busy  out  1  state != IDLE
stall  out  1  hold decode stage this cycle

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE; counter = 0; all outputs 0. Applies immediately, including mid-operation. No hilo_we is issued for the aborted operation.
- Decode (combinational):
  - SPECIAL with ADD/ADDU -> ALU_add; SUBU -> ALU_sub; SLL -> ALU_sll; SRA -> ALU_sra; MFHI/MFLO -> ALU_rs_pass; SYSCALL/JR/MULT/MULTU/DIV/DIVU -> 0; other funct -> ALU_undef.
  - SW/SB/LW/LB/ADDIU -> ALU_add; ANDI -> ALU_AND; ORI -> ALU_OR; LUI -> ALU_slli; SLTI/SLTIU -> ALU_slt; other opcode -> ALU_undef.
- alu_op_q update, every clock:
  - flush, stall, or !valid_in -> 0 (bubble).
  - Otherwise -> decoded value.
- md op = valid_in & SPECIAL & funct in {011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU}.
- hilo read = valid_in & SPECIAL & funct in {010000 MFHI, 010010 MFLO}.
- stall = (state != IDLE) & (md op | hilo read) & !flush. Combinational.
- FSM:
  - IDLE: on md op & !flush -> BUSY. Pulse md_start. Latch md_is_div = funct[1] and md_signed = !funct[0]. Load counter = (div ? DIV_CYCLES : MULT_CYCLES) - 1.
  - BUSY: md_step = 1. If flush -> IDLE (abort, no hilo_we). Else if counter == 0 -> DONE. Else counter decrements.
  - DONE: hilo_we = 1 for one cycle, then -> IDLE. flush in DONE does not suppress hilo_we: the op is architecturally complete.
- Latency: md_start in cycle 0 (IDLE->BUSY edge). BUSY spans N cycles, md_step high each. hilo_we in cycle N+1. Earliest new md_start or unstalled MFHI/MFLO: cycle N+2.
- Counter width: $clog2(max(DIV_CYCLES, MULT_CYCLES)). Never wraps; never decrements below 0.
- md_is_div and md_signed hold their last value until the next md_start; reset clears them to 0.
- flush & md op in IDLE: flush wins; no start.

Optional Feature:
Macro ALU_SEQ_UNDEF_TRAP_EN.
- Defined: adds output undef_trap (1 bit, reset 0). Registered; high for exactly one cycle after valid_in & !flush & !stall & decode == ALU_undef. Also prints $display with $time, opcode and funct on that cycle (non-zero time only).
- Undefined: port absent; undefined encodings only produce ALU_undef in alu_op_q; no message.

Test Plan:
1. Reset, then valid ADDU (opcode 000000, funct 100001) -> next cycle alu_op_q = ALU_add, stall = 0, busy = 0.
2. WIDTH = 32, valid DIV (funct 011010) -> md_start = 1 cycle 0, md_is_div = 1, md_signed = 1; md_step high cycles 1-32; hilo_we high cycle 33 only; busy low cycle 34.
3. MULTU, then MFLO held valid from cycle 2 -> stall = 1 through cycle 5 (DONE); stall = 0 cycle 6; alu_op_q = ALU_rs_pass cycle 7.
4. DIV, flush asserted in the 5th BUSY cycle -> IDLE next cycle; hilo_we never pulses; alu_op_q = 0 for the flushed slot.
5. reset_n low for half a cycle mid-MULT -> all outputs 0 immediately (no clock edge needed); after release, busy = 0 and no hilo_we.
6. Valid opcode 000000, funct 111111 -> alu_op_q = ALU_undef; with ALU_SEQ_UNDEF_TRAP_EN undef_trap = 1 for one cycle; without the macro, no trap and no message.
